// File: rtl/fetch_sequencer.sv
// Program-counter controller for a synchronous instruction ROM: issues word fetches,
// tracks the single in-flight read, and buffers returned words in a 2-entry queue for decode.
module fetch_sequencer #(
    parameter int              ADDR_W   = 16,
    parameter int              INS_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INS_W-1:0]  mem_ins,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INS_W-1:0]  out_ins,
    output logic [ADDR_W-1:0] out_pc,
    output logic [1:0]        dbg_state
);

    // Queue occupancy doubles as the controller state.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic              squash_q, squash_d;
    logic [1:0]        count_q, count_d;
    logic              head_q, head_d;
    logic [INS_W-1:0]  buf_ins_q [2];
    logic [ADDR_W-1:0] buf_pc_q  [2];

    logic       pop;
    logic       push;
    logic       issue;
    logic       wr_idx;
    logic [2:0] occupancy;

    // Handshake: a word transfers to decode on any posedge where out_valid && out_ready;
    // out_ins/out_pc hold steady while out_valid is high and out_ready is low.
    assign out_valid = (count_q != ST_EMPTY);
    assign pop       = out_valid && out_ready;

    // A redirect flushes the queue, so the returning word must not land in it that cycle.
    assign push      = inflight_q && !squash_q && !redirect_valid;
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = en && !redirect_valid && (occupancy < 3'd2);

    // Tail slot: head for empty/full, the other slot when one word is held.
    assign wr_idx    = head_q ^ count_q[0];

    assign mem_addr  = pc_q;
    assign out_ins   = out_valid ? buf_ins_q[head_q] : '0;
    assign out_pc    = out_valid ? buf_pc_q[head_q]  : '0;
    assign dbg_state = count_q;

    always_comb begin
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = inflight_q;
        squash_d      = 1'b0;
        count_d       = count_q;
        head_d        = head_q;
        if (redirect_valid) begin
            pc_d       = redirect_pc;
            inflight_d = 1'b0;
            squash_d   = inflight_q;
            count_d    = ST_EMPTY;
            head_d     = 1'b0;
        end else begin
            if (issue) begin
                pc_d          = pc_q + 1'b1;
                inflight_pc_d = pc_q;
                inflight_d    = 1'b1;
            end else begin
                inflight_d    = 1'b0;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            head_d  = head_q ^ pop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            squash_q      <= 1'b0;
            count_q       <= ST_EMPTY;
            head_q        <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            squash_q      <= squash_d;
            count_q       <= count_d;
            head_q        <= head_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_ins_q[i] <= '0;
                buf_pc_q[i]  <= '0;
            end
        end else if (push) begin
            buf_ins_q[wr_idx] <= mem_ins;
            buf_pc_q[wr_idx]  <= inflight_pc_q;
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count_q == ST_FULL));

    a_count_legal : assert property (@(posedge clk) disable iff (!rst_n)
        count_q != 2'd3);

endmodule
